// File: rtl/audio_in_stereo_sequencer.sv
// rtl/audio_in_stereo_sequencer.sv - lock-step stereo read sequencer for the audio-in L/R FIFOs
// Pops both channel FIFOs together and presents one stereo frame at a time on a valid/ready port.
module audio_in_stereo_sequencer #(
    parameter int AUDIO_DATA_WIDTH = 32,
    parameter int START_LEVEL      = 4,
    parameter int MAX_SKEW         = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [7:0]                  left_read_space,
    input  logic [7:0]                  right_read_space,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    output logic                        read_left_audio_data_en,
    output logic                        read_right_audio_data_en,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [AUDIO_DATA_WIDTH-1:0] frame_left,
    output logic [AUDIO_DATA_WIDTH-1:0] frame_right,
    output logic                        overrun,
    input  logic                        clear_overrun,
    output logic [15:0]                 frame_count
);

    localparam logic [6:0] START_USED = 7'(START_LEVEL);
    localparam logic [7:0] SKEW_LIMIT = 8'(MAX_SKEW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_CHECK,
        S_POP,
        S_SETTLE,
        S_PRESENT,
        S_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic                        settle_cnt_q, settle_cnt_d;
    logic                        settle_to_check_q, settle_to_check_d;
    logic                        drain_left_q, drain_left_d;
    logic [AUDIO_DATA_WIDTH-1:0] frame_left_q, frame_left_d;
    logic [AUDIO_DATA_WIDTH-1:0] frame_right_q, frame_right_d;
    logic                        overrun_q, overrun_d;
    logic [15:0]                 frame_count_q, frame_count_d;

    logic [6:0] left_used;
    logic [6:0] right_used;
    logic [7:0] skew;
    logic       pop_left;
    logic       pop_right;

    always_comb begin
        left_used  = left_read_space[6:0];
        right_used = right_read_space[6:0];
        if (left_used >= right_used) begin
            skew = {1'b0, left_used} - {1'b0, right_used};
        end else begin
            skew = {1'b0, right_used} - {1'b0, left_used};
        end
    end

    always_comb begin
        state_d           = state_q;
        settle_cnt_d      = settle_cnt_q;
        settle_to_check_d = settle_to_check_q;
        drain_left_d      = drain_left_q;
        frame_left_d      = frame_left_q;
        frame_right_d     = frame_right_q;
        frame_count_d     = frame_count_q;
        pop_left          = 1'b0;
        pop_right         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (left_used >= START_USED && right_used >= START_USED) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (skew > SKEW_LIMIT) begin
                    drain_left_d = left_used > right_used;
                    state_d      = S_DRAIN;
                end else if (left_used == 7'd0 || right_used == 7'd0) begin
                    state_d = S_PREFILL;
                end else begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                pop_left          = left_used != 7'd0;
                pop_right         = right_used != 7'd0;
                frame_left_d      = left_channel_data;
                frame_right_d     = right_channel_data;
                settle_cnt_d      = 1'b0;
                settle_to_check_d = 1'b0;
                state_d           = S_SETTLE;
            end
            S_DRAIN: begin
                pop_left          = drain_left_q && left_used != 7'd0;
                pop_right         = !drain_left_q && right_used != 7'd0;
                settle_cnt_d      = 1'b0;
                settle_to_check_d = 1'b1;
                state_d           = S_SETTLE;
            end
            // Two cycles: one for the FIFO used count, one for the read_space register lag.
            S_SETTLE: begin
                if (settle_cnt_q) begin
                    state_d = settle_to_check_q ? S_CHECK : S_PRESENT;
                end else begin
                    settle_cnt_d = 1'b1;
                end
            end
            S_PRESENT: begin
                if (frame_ready) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d = S_IDLE;
        end

        // A new full condition wins over a clear in the same cycle.
        if (enable && (left_read_space[7] || right_read_space[7])) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            settle_cnt_q      <= 1'b0;
            settle_to_check_q <= 1'b0;
            drain_left_q      <= 1'b0;
            frame_left_q      <= '0;
            frame_right_q     <= '0;
            overrun_q         <= 1'b0;
            frame_count_q     <= 16'd0;
        end else begin
            state_q           <= state_d;
            settle_cnt_q      <= settle_cnt_d;
            settle_to_check_q <= settle_to_check_d;
            drain_left_q      <= drain_left_d;
            frame_left_q      <= frame_left_d;
            frame_right_q     <= frame_right_d;
            overrun_q         <= overrun_d;
            frame_count_q     <= frame_count_d;
        end
    end

    always_comb begin
        read_left_audio_data_en  = pop_left && !reset;
        read_right_audio_data_en = pop_right && !reset;
        frame_valid              = state_q == S_PRESENT;
        frame_left               = frame_left_q;
        frame_right              = frame_right_q;
        overrun                  = overrun_q;
        frame_count              = frame_count_q;
    end

endmodule
